// File: rtl/dm_slave_pkg.sv
// rtl/dm_slave_pkg.sv - shared FSM encoding and byte-lane helpers for dm_slave
// Purpose: state encoding and lane-select / sign-extend helpers, also used by
// the controller bench.
// Ports: none (package).
package dm_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } dm_state_e;

  localparam int LANE_W = 8;
  localparam int LANES  = 4;

  // Little-endian lane pick (lane 0 = bits 7:0), sign-extended to a word.
  function automatic logic [31:0] lane_sext(input logic [31:0] word,
                                            input logic [1:0]  lane);
    logic [7:0] b;
    b = word[{lane, 3'b000} +: LANE_W];
    return {{24{b[7]}}, b};
  endfunction

  // One-hot byte-lane write enable.
  function automatic logic [3:0] lane_mask(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/dm_slave_array.sv
// rtl/dm_slave_array.sv - 32-bit word RAM with byte-lane write enable
// Purpose: data storage; synchronous byte-lane writes, asynchronous read of
// the same word index. Contents are not affected by reset.
// Ports:
//   clk   in  clock
//   be    in  4   byte-lane write enables (lane i = bits 8i+7:8i)
//   idx   in  IDX_W word index for both read and write
//   wdata in  32  write data, lanes already positioned
//   rdata out 32  word at idx (combinational)
module dm_slave_array #(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [2**IDX_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dm_slave.sv
// rtl/dm_slave.sv - data-memory responder with configurable wait states
// Purpose: answers CPU load/store requests over req/ready with WAIT_CYC wait
// states; word and byte access, misaligned word access flagged on err.
// Ports:
//   clk     in  clock
//   rst     in  asynchronous active-low reset
//   req     in  request valid, held until ready seen
//   we      in  1=store, 0=load
//   byte_op in  1=byte access, 0=word access
//   addr    in  ADDR_W byte address
//   wdata   in  32 store data (byte stores use wdata[7:0])
//   ready   out one-cycle response strobe
//   rdata   out 32 load data, held until the next load response
//   err     out misaligned word access, valid with ready
module dm_slave
  import dm_slave_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic              byte_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam int         IDX_W    = ADDR_W - 2;
  localparam logic [3:0] CNT_LOAD = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

  dm_state_e state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       accept, commit;

  logic [ADDR_W-1:0] addr_q;
  logic              we_q, byte_q;
  logic [31:0]       wdata_q;

  logic [ADDR_W-1:0] c_addr;
  logic              c_we, c_byte;
  logic [31:0]       c_wdata;

  logic        misalign;
  logic [1:0]  lane;
  logic [3:0]  wr_be;
  logic [31:0] wr_word, rd_word, load_val;
  logic [31:0] rdata_q;
  logic        err_q;

  // With no wait states the commit edge is the accept edge, so the request
  // fields must come straight from the inputs rather than from the latch.
  always_comb begin
    if (state == ST_IDLE) begin
      c_addr  = addr;
      c_we    = we;
      c_byte  = byte_op;
      c_wdata = wdata;
    end else begin
      c_addr  = addr_q;
      c_we    = we_q;
      c_byte  = byte_q;
      c_wdata = wdata_q;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    commit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (WAIT_CYC == 0) begin
            state_nx = ST_RESP;
            commit   = 1'b1;
          end else begin
            state_nx = ST_WAIT;
            cnt_nx   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = ST_RESP;
          commit   = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      wdata_q <= 32'h0;
    end else if (accept) begin
      addr_q  <= addr;
      we_q    <= we;
      byte_q  <= byte_op;
      wdata_q <= wdata;
    end
  end

  assign lane     = c_addr[1:0];
  assign misalign = !c_byte && (lane != 2'b00);
  assign wr_word  = c_byte ? {4{c_wdata[7:0]}} : c_wdata;

  // Array has no reset; gating with rst keeps an aborted store out of memory.
  always_comb begin
    wr_be = 4'h0;
    if (commit && c_we && rst) begin
      if (c_byte)         wr_be = lane_mask(lane);
      else if (!misalign) wr_be = 4'hF;
    end
  end

  always_comb begin
    load_val = rd_word;
    if (c_byte)        load_val = lane_sext(rd_word, lane);
    else if (misalign) load_val = 32'h0;
  end

  dm_slave_array #(.IDX_W(IDX_W)) u_array (
    .clk   (clk),
    .be    (wr_be),
    .idx   (c_addr[ADDR_W-1:2]),
    .wdata (wr_word),
    .rdata (rd_word)
  );

  // Stores leave rdata untouched; err always reflects the alignment check.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (commit) begin
      err_q <= misalign;
      if (!c_we) rdata_q <= load_val;
    end
  end

  assign ready = (state == ST_RESP);
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_dm_slave.sv
// tb/tb_dm_slave.sv - self-checking bench for dm_slave
module tb_dm_slave;
  import dm_slave_pkg::*;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0, we = 1'b0, byte_op = 1'b0;
  logic [9:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        ready, err;
  logic [31:0] rdata;

  logic        req0 = 1'b0, we0 = 1'b0, bo0 = 1'b0;
  logic [9:0]  addr0 = '0;
  logic [31:0] wd0 = '0;
  logic        ready0, err0;
  logic [31:0] rdata0;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  dm_slave #(.ADDR_W(10), .WAIT_CYC(W)) dut2 (
    .clk(clk), .rst(rst), .req(req), .we(we), .byte_op(byte_op),
    .addr(addr), .wdata(wdata), .ready(ready), .rdata(rdata), .err(err)
  );

  dm_slave #(.ADDR_W(10), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .byte_op(bo0),
    .addr(addr0), .wdata(wd0), .ready(ready0), .rdata(rdata0), .err(err0)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model for dut2: a transaction accepted at edge k commits at
  // edge k+W, ready is seen in the cycle after that edge, and the next
  // accept is possible two edges after the commit.
  logic [31:0] mmem [0:255];
  int          cyc = 0;
  int          commit_at = -10;
  int          resp_cyc = -10;
  bit          pend = 1'b0;
  logic        t_we, t_b;
  logic [9:0]  t_a;
  logic [31:0] t_d;
  logic [31:0] exp_rdata = 32'h0;
  logic        exp_err = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      pend = 1'b0;
      commit_at = -10;
      resp_cyc = -10;
      exp_rdata = 32'h0;
      exp_err = 1'b0;
    end else begin
      cyc++;
      if (!pend && req && cyc >= resp_cyc + 2) begin
        pend = 1'b1;
        t_we = we; t_b = byte_op; t_a = addr; t_d = wdata;
        commit_at = cyc + W;
      end
      if (pend && cyc == commit_at) begin
        int idx, sh;
        logic [31:0] byt;
        pend = 1'b0;
        resp_cyc = cyc;
        idx = int'(t_a) / 4;
        sh = 8 * (int'(t_a) % 4);
        if (!t_b && (int'(t_a) % 4) != 0) begin
          exp_err = 1'b1;
          if (!t_we) exp_rdata = 32'h0;
        end else begin
          exp_err = 1'b0;
          if (t_we) begin
            if (t_b) mmem[idx] = (mmem[idx] & ~(32'hFF << sh)) | ((t_d & 32'hFF) << sh);
            else     mmem[idx] = t_d;
          end else if (t_b) begin
            byt = (mmem[idx] >> sh) & 32'hFF;
            exp_rdata = (byt >= 128) ? byt + 32'hFFFFFF00 : byt;
          end else begin
            exp_rdata = mmem[idx];
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("cmp_ready", {31'b0, ready}, {31'b0, (rst && resp_cyc == cyc)});
      check("cmp_rdata", rdata, exp_rdata);
      check("cmp_err", {31'b0, err}, {31'b0, exp_err});
    end
  end

  task automatic txn(input logic w, input logic b, input logic [9:0] a,
                     input logic [31:0] d, output logic [31:0] rd, output logic e);
    bit seen;
    int lat;
    @(negedge clk);
    we = w; byte_op = b; addr = a; wdata = d; req = 1'b1;
    seen = 1'b0; lat = 0; rd = 'x; e = 1'bx;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(negedge clk);
      if (ready) begin
        seen = 1'b1; lat = n; rd = rdata; e = err;
      end
    end
    req = 1'b0;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL txn_timeout addr=%h: got no ready, expected ready within 20 cycles", a);
    end else begin
      check("latency", lat, W + 1);
    end
  endtask

  logic [31:0] rd;
  logic        e;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'b0, ready}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_state", {30'b0, dut2.state}, {30'b0, ST_IDLE});
    check("rst_ready0", {31'b0, ready0}, 32'h0);
    chk_en = 1'b1;

    // 1: word store/load
    txn(1'b1, 1'b0, 10'h010, 32'hDEADBEEF, rd, e);
    check("t1_sw_err", {31'b0, e}, 32'h0);
    txn(1'b0, 1'b0, 10'h010, 32'h0, rd, e);
    check("t1_lw", rd, 32'hDEADBEEF);

    // 2: byte store into lane 3, byte loads with sign extension
    txn(1'b1, 1'b0, 10'h010, 32'h11223344, rd, e);
    txn(1'b1, 1'b1, 10'h013, 32'h00000080, rd, e);
    check("t2_sb_err", {31'b0, e}, 32'h0);
    txn(1'b0, 1'b0, 10'h010, 32'h0, rd, e);
    check("t2_lw", rd, 32'h80223344);
    txn(1'b0, 1'b1, 10'h013, 32'h0, rd, e);
    check("t2_lb3", rd, 32'hFFFFFF80);
    txn(1'b0, 1'b1, 10'h010, 32'h0, rd, e);
    check("t2_lb0", rd, 32'h00000044);

    // 3: misaligned word access
    txn(1'b0, 1'b0, 10'h012, 32'h0, rd, e);
    check("t3_lw_err", {31'b0, e}, 32'h1);
    check("t3_lw_rdata", rd, 32'h0);
    txn(1'b1, 1'b0, 10'h012, 32'hFFFFFFFF, rd, e);
    check("t3_sw_err", {31'b0, e}, 32'h1);
    txn(1'b0, 1'b0, 10'h010, 32'h0, rd, e);
    check("t3_unchanged", rd, 32'h80223344);

    // 4: zero wait states, req held high continuously
    @(negedge clk);
    we0 = 1'b1; bo0 = 1'b0; addr0 = 10'h004; wd0 = 32'hA5A50001; req0 = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      check("t4_ready_pattern", {31'b0, ready0}, {31'b0, (n % 2 == 1)});
    end
    we0 = 1'b0;
    @(negedge clk);
    check("t4_lw_ready", {31'b0, ready0}, 32'h1);
    check("t4_lw_rdata", rdata0, 32'hA5A50001);
    check("t4_lw_err", {31'b0, err0}, 32'h0);
    req0 = 1'b0;

    // 5: reset mid-transaction aborts the store
    txn(1'b1, 1'b0, 10'h020, 32'hCAFEF00D, rd, e);
    @(negedge clk);
    we = 1'b1; byte_op = 1'b0; addr = 10'h020; wdata = 32'h12345678; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("t5_no_ready", {31'b0, ready}, 32'h0);
    end
    check("t5_state", {30'b0, dut2.state}, {30'b0, ST_IDLE});
    check("t5_rdata_rst", rdata, 32'h0);
    txn(1'b0, 1'b0, 10'h020, 32'h0, rd, e);
    check("t5_prior", rd, 32'hCAFEF00D);

    // 6: req dropped during WAIT
    @(negedge clk);
    we = 1'b0; byte_op = 1'b0; addr = 10'h010; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("t6_ready_n1", {31'b0, ready}, 32'h0);
    for (int n = 2; n <= 8; n++) begin
      @(negedge clk);
      check("t6_ready", {31'b0, ready}, {31'b0, (n == 3)});
      if (n == 3) check("t6_rdata", rdata, 32'h80223344);
    end
    check("t6_state", {30'b0, dut2.state}, {30'b0, ST_IDLE});

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/dm_slave.md
Name: dm_slave

Overview:
- Data-memory responder for the multi-cycle MIPS datapath. It answers load/store requests from the CPU's memory stage over a req/ready handshake with a configurable number of wait states.
- It replaces the zero-latency data memory so the controller FSM can be exercised against a slow memory.
- It supports word access and byte access (lb/sb) and flags misaligned word accesses.

Parameters:
- ADDR_W, 10, byte-address width; memory holds 2^(ADDR_W-2) 32-bit words.
- WAIT_CYC, 2, wait states inserted between accept and response (0..15).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- req  in  1  request valid from CPU; held high until ready seen
- we  in  1  1=store, 0=load
- byte_op  in  1  1=byte access (sb/lb), 0=word access
- addr  in  ADDR_W  byte address (alurOut[ADDR_W-1:0])
- wdata  in  32  store data (busB); byte stores use wdata[7:0]
- ready  out  1  one-cycle response strobe
- rdata  out  32  load data, valid while ready=1, held until the next response
- err  out  1  misaligned word access, valid with ready

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE; ready=0, err=0, rdata=32'h0, wait counter=0.
  - Memory array is not cleared by reset.
- FSM states:
  - IDLE: when req=1 at a rising edge, latch addr, we, byte_op, wdata.
    - If WAIT_CYC=0, go to RESP.
    - Otherwise go to WAIT with cnt=WAIT_CYC-1.
  - WAIT: if cnt==0, go to RESP; else decrement cnt. The req level is ignored.
  - RESP: ready=1 for exactly one cycle; next state IDLE.
- Commit: the memory write and the rdata/err registers update on the edge that enters RESP. Latency from the accepting edge to ready high is WAIT_CYC+1 cycles.
- Word access:
  - Index = addr[ADDR_W-1:2].
  - If addr[1:0]!=0: no write, rdata=32'h0, err=1.
- Byte load: select lane addr[1:0] little-endian (lane 0 = bits 7:0), sign-extend to 32 bits.
- Byte store: write only lane addr[1:0] with wdata[7:0]; other lanes unchanged; err=0.
- Store response: rdata holds its previous value; err reflects the alignment check only.
- Handshake rules:
  - The requester drops req on the edge where it samples ready=1.
  - If req is still high in the cycle after RESP (in IDLE), a new transaction is accepted. Minimum spacing is therefore one IDLE cycle between responses.
- Protocol violation: if req drops during WAIT, the transaction still completes and ready pulses.
- Address wrap: upper address bits beyond ADDR_W are not presented, so every index is in range.
- Reset mid-transaction: aborts the transaction. No write is performed if reset arrives before the commit edge; ready stays 0.
- Reads and writes to the same word in back-to-back transactions: the second transaction sees the first's data.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'b00, WAIT=2'b01, RESP=2'b10) and the lane-select/sign-extend constants, reused by the controller bench.
- One natural sub-module: dm_slave_array, the 32-bit word RAM with a 4-bit byte-lane write enable and asynchronous read. The FSM, counter and lane logic stay in dm_slave.

Test Plan:
1. WAIT_CYC=2, rst released; sw addr=0x010 wdata=0xDEADBEEF -> ready high exactly 3 cycles after accept, err=0; then lw 0x010 -> rdata=0xDEADBEEF.
2. sb addr=0x013 wdata=0x00000080 over word 0x11223344 at 0x010 -> lw 0x010 returns 0x80223344; lb 0x013 returns 0xFFFFFF80; lb 0x010 returns 0x00000044.
3. lw addr=0x012 -> ready with err=1, rdata=0; sw 0x012 -> err=1 and word at 0x010 unchanged.
4. WAIT_CYC=0 -> ready one cycle after accept. With req held high continuously, responses occur every 2 cycles with ready never high two cycles in a row.
5. Assert rst low one cycle after accepting sw 0x020=0x12345678 (WAIT_CYC=2) -> ready never pulses, state IDLE, lw 0x020 afterwards returns the prior contents.
6. Drop req during WAIT -> ready still pulses once at the scheduled cycle; the FSM then sits in IDLE with no further ready.
